// File: rtl/nco_sweep_pkg.sv
// Shared types and constants for the NCO frequency-sweep controller.
package nco_sweep_pkg;

    localparam int APR_DEF = 32;
    localparam int DWW_DEF = 16;

    typedef enum logic [1:0] {
        SWP_SINGLE = 2'd0,
        SWP_SAW    = 2'd1,
        SWP_TRI    = 2'd2
    } sweep_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

    // Raw 2-bit mode is kept so the reserved code 3 survives and decodes as single.
    typedef struct packed {
        logic [APR_DEF-1:0] f_start;
        logic [APR_DEF-1:0] f_stop;
        logic [APR_DEF-1:0] f_step;
        logic [DWW_DEF-1:0] dwell;
        logic [1:0]         mode;
    } sweep_cfg_t;

    function automatic sweep_cfg_t cfg_coerce(input sweep_cfg_t c);
        sweep_cfg_t r;
        r = c;
        if (r.f_step == '0) r.f_step = APR_DEF'(1);
        return r;
    endfunction

endpackage

// File: rtl/nco_sweep_step.sv
// Sweep datapath: current increment, dwell down-counter and direction flag.
module nco_sweep_step #(
    parameter int APR = 32,
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_stop,
    input  logic [APR-1:0] f_step,
    input  logic [DWW-1:0] dwell,
    input  logic           run,
    input  logic           clear,
    input  logic           init,
    input  logic [APR-1:0] init_value,
    input  logic [DWW-1:0] init_dwell,
    input  logic           adv,
    input  logic           rev_set,
    output logic [APR-1:0] cur,
    output logic           load,
    output logic           at_endpoint,
    output logic           rev_done,
    output logic           rev
);

    logic [APR-1:0] nxt_fwd;
    logic [APR-1:0] nxt_rev;
    logic [APR-1:0] next_value;
    logic [DWW-1:0] cnt;

    // One step from c toward tgt, clamped at tgt using the carry/borrow bit.
    function automatic logic [APR-1:0] step_toward(input logic [APR-1:0] c,
                                                   input logic [APR-1:0] tgt,
                                                   input logic [APR-1:0] stp);
        logic [APR:0] sum;
        logic [APR-1:0] res;
        if (tgt >= c) begin
            sum = {1'b0, c} + {1'b0, stp};
            res = (sum > {1'b0, tgt}) ? tgt : sum[APR-1:0];
        end else begin
            sum = {1'b0, c} - {1'b0, stp};
            res = (sum[APR] || (sum[APR-1:0] < tgt)) ? tgt : sum[APR-1:0];
        end
        return res;
    endfunction

    assign nxt_fwd     = step_toward(cur, f_stop, f_step);
    assign nxt_rev     = step_toward(cur, f_start, f_step);
    assign next_value  = (rev || rev_set) ? nxt_rev : nxt_fwd;
    assign load        = (cnt == '0);
    assign at_endpoint = !rev && (cur == f_stop);
    assign rev_done    = (nxt_rev == f_start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= '0;
            cnt <= '0;
            rev <= 1'b0;
        end else if (clear) begin
            cur <= '0;
            cnt <= '0;
            rev <= 1'b0;
        end else if (init) begin
            cur <= init_value;
            cnt <= init_dwell;
            rev <= 1'b0;
        end else if (adv) begin
            cur <= next_value;
            cnt <= dwell;
            rev <= rev | rev_set;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Chirp controller driving the NCO phase increment and clock enable.
// APR/DWW must match the widths in nco_sweep_pkg (the config struct is sized there).
//
// state | meaning
// IDLE  | no sweep running; tone held (after a single sweep) or silenced (abort/reset)
// RUN   | stepping the increment through the active configuration
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR = APR_DEF,
    parameter int DWW = DWW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [APR-1:0] cfg_f_start,
    input  logic [APR-1:0] cfg_f_stop,
    input  logic [APR-1:0] cfg_f_step,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [1:0]     cfg_mode,
    input  logic           start,
    input  logic           abort,
    output logic [APR-1:0] phi_inc_o,
    output logic           clken_o,
    output logic           busy,
    output logic           sweep_done
);

    sweep_state_t state_q, state_d;
    sweep_cfg_t   shadow, act, act_d;
    logic         pend, act_valid;
    logic         clken_q, clken_d;
    logic         done_q, done_d;
    logic         accept, xfer, init, adv, rev_set, clear;
    logic         load, at_endpoint, rev_done, rev;

    assign accept     = cfg_valid && !pend;
    assign cfg_ready  = !pend;
    assign busy       = (state_q == RUN);
    assign clken_o    = clken_q;
    assign sweep_done = done_q;

    // Config that will be active after this edge; a transfer reads the pre-edge shadow.
    assign act_d = xfer ? cfg_coerce(shadow) : act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            clken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clken_q <= clken_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            act       <= '0;
            pend      <= 1'b0;
            act_valid <= 1'b0;
        end else begin
            if (accept) begin
                shadow <= '{f_start: cfg_f_start, f_stop: cfg_f_stop, f_step: cfg_f_step,
                            dwell: cfg_dwell, mode: cfg_mode};
            end
            if (xfer) begin
                act       <= act_d;
                act_valid <= 1'b1;
            end
            pend <= accept | (pend & ~xfer);
        end
    end

    always_comb begin
        state_d = state_q;
        clken_d = clken_q;
        done_d  = 1'b0;
        xfer    = 1'b0;
        init    = 1'b0;
        adv     = 1'b0;
        rev_set = 1'b0;
        clear   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            clken_d = 1'b0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (pend || act_valid)) begin
                        xfer    = pend;
                        init    = 1'b1;
                        state_d = RUN;
                        clken_d = 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        xfer = pend;
                        init = 1'b1;
                    end else if (load) begin
                        if (at_endpoint && (act.mode != SWP_SAW) && (act.mode != SWP_TRI)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (at_endpoint && (act.mode == SWP_TRI) && !rev_done) begin
                            adv     = 1'b1;
                            rev_set = 1'b1;
                        end else if (at_endpoint || (rev && rev_done)) begin
                            // Period boundary: the next period opens on f_start.
                            done_d = 1'b1;
                            xfer   = pend;
                            init   = 1'b1;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    nco_sweep_step #(
        .APR(APR),
        .DWW(DWW)
    ) u_step (
        .clk        (clk),
        .reset      (reset),
        .f_start    (act.f_start),
        .f_stop     (act.f_stop),
        .f_step     (act.f_step),
        .dwell      (act.dwell),
        .run        (busy),
        .clear      (clear),
        .init       (init),
        .init_value (act_d.f_start),
        .init_dwell (act_d.dwell),
        .adv        (adv),
        .rev_set    (rev_set),
        .cur        (phi_inc_o),
        .load       (load),
        .at_endpoint(at_endpoint),
        .rev_done   (rev_done),
        .rev        (rev)
    );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed vector table, hand sequences and a randomized model comparison.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_f_start, cfg_f_stop, cfg_f_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        start, abort;
    logic [31:0] phi_inc_o;
    logic        clken_o, busy, sweep_done;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        cv, st, ab;
        logic [31:0] fs, fe, fp;
        logic [15:0] dw;
        logic [1:0]  md;
        logic [31:0] e_phi;
        logic        e_clk, e_busy, e_done, e_rdy;
    } vec_t;

    vec_t   vecs[$];
    int     tri_exp[11] = '{0, 1, 2, 3, 2, 1, 50, 51, 52, 51, 50};
    longint m_phi[$];
    bit     m_done[$];
    bit     m_busy[$];

    nco_sweep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_f_start(cfg_f_start),
        .cfg_f_stop (cfg_f_stop),
        .cfg_f_step (cfg_f_step),
        .cfg_dwell  (cfg_dwell),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .abort      (abort),
        .phi_inc_o  (phi_inc_o),
        .clken_o    (clken_o),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic cv, st, ab, input logic [31:0] fs, fe, fp,
                       input logic [15:0] dw, input logic [1:0] md,
                       input logic [31:0] ephi, input logic eclk, ebusy, edone, erdy);
        vec_t v;
        v.cv = cv; v.st = st; v.ab = ab;
        v.fs = fs; v.fe = fe; v.fp = fp; v.dw = dw; v.md = md;
        v.e_phi = ephi; v.e_clk = eclk; v.e_busy = ebusy; v.e_done = edone; v.e_rdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic set_cfg(input logic [31:0] fs, fe, fp, input logic [15:0] dw, input logic [1:0] md);
        cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = fp; cfg_dwell = dw; cfg_mode = md;
    endtask

    // Expected per-cycle trace after a start, built from the sweep rules as a list of period values.
    task automatic build_model(input longint fs, input longint fe, input longint stp,
                               input int dw, input int md, input int n);
        longint p[$];
        longint v, s;
        m_phi.delete(); m_done.delete(); m_busy.delete();
        s = (stp == 0) ? 1 : stp;
        v = fs;
        p.push_back(v);
        while (v != fe) begin
            if (fe >= fs) v = (v + s > fe) ? fe : v + s;
            else          v = (v - s < fe) ? fe : v - s;
            p.push_back(v);
        end
        if (md == 2) begin
            v = fe;
            while (v != fs) begin
                if (fs >= fe) v = (v + s > fs) ? fs : v + s;
                else          v = (v - s < fs) ? fs : v - s;
                if (v != fs) p.push_back(v);
            end
        end
        for (int r = 0; m_phi.size() < n; r++) begin
            if (r > 0 && (md == 0 || md == 3)) begin
                m_phi.push_back(fe); m_done.push_back(r == 1); m_busy.push_back(1'b0);
            end else begin
                foreach (p[i]) begin
                    for (int d = 0; d <= dw; d++) begin
                        m_phi.push_back(p[i]);
                        m_done.push_back(r > 0 && i == 0 && d == 0);
                        m_busy.push_back(1'b1);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r_fs, r_fe, r_fp;
        logic [15:0] r_dw;
        int          r_md, delta;
        longint      lfs, lfe;

        reset = 1'b1; cfg_valid = 0; start = 0; abort = 0;
        set_cfg(0, 0, 0, 0, 0);

        //  cv st ab  fs           fe           fp           dw md  phi          ck by dn rd
        add(0, 1, 0, 0,           0,           0,           0, 0, 0,           0, 0, 0, 1);
        add(1, 0, 0, 100,         130,         10,          1, 0, 0,           0, 0, 0, 0);
        add(0, 1, 0, 0,           0,           0,           0, 0, 100,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 100,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 110,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 110,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 120,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 120,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 130,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 130,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 130,         1, 0, 1, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 130,         1, 0, 0, 1);
        add(1, 0, 0, 1000,        975,         10,          0, 0, 130,         1, 0, 0, 0);
        add(0, 1, 0, 0,           0,           0,           0, 0, 1000,        1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 990,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 980,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 975,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 975,         1, 0, 1, 1);
        add(1, 0, 0, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20,    0, 0, 975,         1, 0, 0, 0);
        add(0, 1, 0, 0,           0,           0,           0, 0, 32'hFFFFFFF0, 1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 32'hFFFFFFFF, 1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 32'hFFFFFFFF, 1, 0, 1, 1);
        add(1, 0, 0, 5,           8,           0,           0, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
        add(0, 1, 0, 0,           0,           0,           0, 0, 5,           1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 6,           1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 7,           1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 8,           1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 5,           1, 1, 1, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 6,           1, 1, 0, 1);
        add(0, 0, 1, 0,           0,           0,           0, 0, 0,           0, 0, 0, 1);
        add(1, 1, 0, 200,         210,         5,           0, 0, 5,           1, 1, 0, 0);
        add(0, 0, 0, 0,           0,           0,           0, 0, 6,           1, 1, 0, 0);
        add(0, 1, 0, 0,           0,           0,           0, 0, 200,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 205,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 210,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 210,         1, 0, 1, 1);
        add(0, 1, 1, 0,           0,           0,           0, 0, 0,           0, 0, 0, 1);
        add(0, 1, 0, 0,           0,           0,           0, 0, 200,         1, 1, 0, 1);
        add(0, 0, 0, 0,           0,           0,           0, 0, 205,         1, 1, 0, 1);
        add(0, 1, 0, 0,           0,           0,           0, 0, 200,         1, 1, 0, 1);
        add(0, 0, 1, 0,           0,           0,           0, 0, 0,           0, 0, 0, 1);

        #2;
        chk("reset.phi", phi_inc_o, 0);
        chk("reset.clken", clken_o, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", sweep_done, 0);
        chk("reset.ready", cfg_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cfg_valid = vecs[i].cv; start = vecs[i].st; abort = vecs[i].ab;
            set_cfg(vecs[i].fs, vecs[i].fe, vecs[i].fp, vecs[i].dw, vecs[i].md);
            @(negedge clk);
            chk($sformatf("vec%0d.phi", i), phi_inc_o, vecs[i].e_phi);
            chk($sformatf("vec%0d.clken", i), clken_o, vecs[i].e_clk);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d.done", i), sweep_done, vecs[i].e_done);
            chk($sformatf("vec%0d.ready", i), cfg_ready, vecs[i].e_rdy);
        end
        cfg_valid = 0; start = 0; abort = 0;

        // Triangle with a config arriving mid-sweep.
        cfg_valid = 1; set_cfg(0, 3, 1, 0, 2);
        @(negedge clk);
        chk("tri.ready_pend", cfg_ready, 0);
        cfg_valid = 0; start = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = 0; cfg_valid = 0;
            chk($sformatf("tri%0d.phi", i), phi_inc_o, tri_exp[i]);
            chk($sformatf("tri%0d.done", i), sweep_done, (i == 6 || i == 10));
            chk($sformatf("tri%0d.ready", i), cfg_ready, (i >= 2 && i <= 5) ? 0 : 1);
            chk($sformatf("tri%0d.busy", i), busy, 1);
            if (i == 1) begin
                cfg_valid = 1; set_cfg(50, 52, 1, 0, 2);
            end
        end

        // Asynchronous reset between edges while sweeping.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset.phi", phi_inc_o, 0);
        chk("areset.clken", clken_o, 0);
        chk("areset.busy", busy, 0);
        chk("areset.done", sweep_done, 0);
        chk("areset.ready", cfg_ready, 1);
        #3 reset = 1'b0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("areset.start_ignored_phi", phi_inc_o, 0);
        chk("areset.start_ignored_busy", busy, 0);
        chk("areset.start_ignored_clken", clken_o, 0);
        cfg_valid = 1; set_cfg(7, 9, 1, 0, 0);
        @(negedge clk);
        cfg_valid = 0; start = 1;
        @(negedge clk);
        start = 0;
        chk("areset.reload_phi", phi_inc_o, 7);
        chk("areset.reload_busy", busy, 1);

        // Randomized sweeps against the trace model.
        for (int t = 0; t < 30; t++) begin
            r_fs = (($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 50) : $urandom);
            lfs  = {32'h0, r_fs};
            delta = $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) lfe = (lfs + delta > 64'hFFFFFFFF) ? 64'hFFFFFFFF : lfs + delta;
            else                           lfe = (lfs - delta < 0) ? 0 : lfs - delta;
            r_fe = lfe[31:0];
            r_fp = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 15);
            r_dw = 16'($urandom_range(0, 3));
            r_md = $urandom_range(0, 3);
            build_model(lfs, lfe, {32'h0, r_fp}, r_dw, r_md, 40);

            @(negedge clk);
            abort = 1;
            @(negedge clk);
            abort = 0; cfg_valid = 1; set_cfg(r_fs, r_fe, r_fp, r_dw, 2'(r_md));
            @(negedge clk);
            cfg_valid = 0; start = 1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                start = 0;
                chk($sformatf("rnd%0d.c%0d.phi", t, c), phi_inc_o, m_phi[c]);
                chk($sformatf("rnd%0d.c%0d.done", t, c), sweep_done, m_done[c]);
                chk($sformatf("rnd%0d.c%0d.busy", t, c), busy, m_busy[c]);
                chk($sformatf("rnd%0d.c%0d.clken", t, c), clken_o, 1);
                chk($sformatf("rnd%0d.c%0d.ready", t, c), cfg_ready, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep (chirp) controller that sits directly upstream of the NCO core. It generates the NCO's phase-increment word and clock enable.
- Steps the phase increment from a start value to a stop value, with a programmable step size and dwell time.
- Sweep modes: single-shot, repeating sawtooth, or triangle.
- Configuration is double-buffered through a valid/ready handshake, so new sweep settings take effect only at a sweep boundary.

Parameters:
APR, 32, phase-increment width; must equal the NCO accumulator width.
DWW, 16, dwell counter width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration word valid
cfg_ready  out  1  shadow register free (equals !pend)
cfg_f_start  in  APR  sweep start increment, unsigned
cfg_f_stop  in  APR  sweep stop increment, unsigned
cfg_f_step  in  APR  step magnitude, unsigned
cfg_dwell  in  DWW  extra cycles each value is held (hold time = dwell+1)
cfg_mode  in  2  0 = single, 1 = saw repeat, 2 = triangle, 3 = reserved (treated as single)
start  in  1  one-cycle pulse: begin or restart sweep
abort  in  1  one-cycle pulse: stop sweep and silence NCO
phi_inc_o  out  APR  registered phase increment to NCO phi_inc_i
clken_o  out  1  registered enable to NCO clken
busy  out  1  high in state RUN
sweep_done  out  1  one-cycle pulse at end of each sweep period

Behaviour:
- Reset (async): state=IDLE, phi_inc_o=0, clken_o=0, busy=0, sweep_done=0, pend=0, act_valid=0, cfg_ready=1.
- Configuration handshake:
  - Accepted on cfg_valid && cfg_ready; fields are stored in the shadow register and pend is set.
  - cfg_ready=0 while pend=1.
  - Shadow-to-active transfer happens at start, or at a period boundary in modes 1 and 2. The transfer clears pend and sets act_valid.
  - A transfer uses the shadow contents from before the clock edge. A config accepted in the same cycle stays pending.
- Step coercion: f_step=0 is coerced to 1 when transferred into the active set.
- Direction: up if f_stop >= f_start, else down.
- Next-value arithmetic:
  - Computed in APR+1 bits.
  - Up: next = min(cur+step, f_stop).
  - Down: next = max(cur-step, f_stop), using the borrow to clamp.
  - Wrap-around of the increment word never occurs.
- State IDLE:
  - start with (pend || act_valid): transfer if pend, then enter RUN.
  - start with neither pend nor act_valid is ignored.
- Latency: start sampled at edge T gives phi_inc_o=f_start, clken_o=1, busy=1 at T+1. The dwell counter loads cfg_dwell.
- State RUN: each value is held for dwell+1 cycles, then the next value is loaded.
- Endpoint reached with dwell expired:
  - Mode 0/3: sweep_done=1 for 1 cycle, go to IDLE. phi_inc_o holds f_stop and clken_o stays 1 (tone continues).
  - Mode 1: sweep_done=1, transfer shadow if pend, phi_inc_o=f_start on the next cycle, remain in RUN.
  - Mode 2:
    - At f_stop: reverse direction, no pulse.
    - Back at f_start: sweep_done=1, transfer if pend, direction forward.
    - Each endpoint is held for exactly one dwell (no double hold).
- f_start == f_stop: a single value held dwell+1 cycles is one period (mode 2: no reversal hold duplication).
- start in RUN: restart from f_start of the active set (after transfer if pend) at the next cycle, with no sweep_done.
- abort in any state: next cycle IDLE, phi_inc_o=0, clken_o=0, busy=0. act_valid and pend are unchanged.
- abort and start in the same cycle: abort wins.
- Reset asserted mid-sweep: all outputs clear asynchronously. Configuration is lost (pend=0, act_valid=0).

Decomposition:
- Package nco_sweep_pkg contains:
  - mode enum (SWP_SINGLE, SWP_SAW, SWP_TRI)
  - state enum (IDLE, RUN)
  - default APR and DWW constants
  - the active/shadow config struct type
- Sub-module nco_sweep_step: registered current value and dwell counter with direction flag. It produces the next value, a load strobe and an at_endpoint flag. The top level holds the FSM, the handshake and the shadow/active registers.

Test Plan:
- Up sweep, mode 0: start=100, stop=130, step=10, dwell=1 -> phi_inc_o = 100,100,110,110,120,120,130,130, then sweep_done pulse; holds 130, clken_o=1, busy=0.
- Clamp and down direction: start=1000, stop=975, step=10, dwell=0 -> 1000, 990, 980, 975, then done. Also start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 -> 0xFFFFFFF0, then 0xFFFFFFFF with no wrap.
- Triangle, mode 2: start=0, stop=3, step=1, dwell=0 -> 0,1,2,3,2,1,0,1,... with sweep_done when 0 is reloaded. A config (start=50) accepted mid-sweep takes effect only after that pulse; cfg_ready stays 0 until then.
- Handshake edge cases:
  - start with no config -> ignored, phi_inc_o=0.
  - cfg_valid in the same cycle as start with pend=0 -> old active set used, new config pending.
  - step=0 -> behaves as step=1.
- Abort/restart: abort mid-RUN -> next cycle phi_inc_o=0, clken_o=0. abort+start in the same cycle -> IDLE. start during RUN -> f_start on the next cycle, no sweep_done.
- Async reset asserted between clock edges mid-sweep -> outputs 0 immediately, cfg_ready=1. After release, start is ignored until a new config is loaded.
